// File: rtl/alu_issue_unit.sv
// ALU issue/execute stage: round-robin pick of a ready station slot, two-stage execute, result to CDB.
// Latency: slot eligible at edge N -> issue reg at N -> result reg at N+1, presented until consumed.
// Backpressure: cdb_stall holds the result reg; the issue reg and new grants stall behind it.

package alu_issue_pkg;

    typedef enum logic [2:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SRL, ALU_SRA, ALU_XOR, ALU_OR, ALU_AND
    } alu_op_t;

    typedef enum logic [2:0] {
        CMP_BEQ, CMP_BNE, CMP_BLT, CMP_BGE, CMP_BLTU, CMP_BGEU
    } cmp_op_t;

    typedef struct packed {
        logic        valid;
        logic [3:0]  tag;
        logic [31:0] r1;
        logic [31:0] r2;
        alu_op_t     alu_opcode;
        cmp_op_t     cmp_opcode;
    } rs_t;

    typedef struct packed {
        logic        rdy;
        logic [3:0]  tag;
        logic [31:0] data;
    } sal_t;

endpackage

module alu_issue_unit
    import alu_issue_pkg::*;
#(
    parameter int size = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  rs_t               data [size],
    input  logic [size-1:0]   acu_operation,
    input  logic [size-1:0]   ready,
    input  logic              cdb_stall,
    output sal_t              broadcast_bus [size],
    output logic              cdb_valid,
    output logic [3:0]        cdb_tag,
    output logic [31:0]       cdb_data,
    output logic              busy
);

    localparam int PW = (size > 1) ? $clog2(size) : 1;

    typedef struct packed {
        logic [PW-1:0] slot;
        logic [3:0]    tag;
        logic [31:0]   r1;
        logic [31:0]   r2;
        alu_op_t       alu_op;
        cmp_op_t       cmp_op;
        logic          acu;
    } iss_t;

    // Pipeline state
    logic          iss_vld;
    iss_t          iss_q;
    logic          res_vld;
    logic [PW-1:0] res_slot;
    logic [3:0]    res_tag;
    logic [31:0]   res_dat;
    logic [size-1:0] inflight;
    logic [PW-1:0] rr_ptr;

    // Handshake terms
    logic          consume;
    logic          res_free;
    logic          iss_adv;
    logic          iss_free;
    logic          grant;

    logic [size-1:0] elig;
    logic          gnt_vld;
    logic [PW-1:0] gnt_slot;
    logic [PW-1:0] rr_idx;
    logic [PW-1:0] rr_next;

    logic [31:0]   alu_res;
    logic          cmp_res;
    logic [31:0]   exe_res;
    logic [size-1:0] bb_rdy;

    assign consume  = res_vld & ~cdb_stall;
    assign res_free = ~res_vld | consume;
    assign iss_adv  = iss_vld & res_free;
    assign iss_free = ~iss_vld | iss_adv;
    assign grant    = gnt_vld & iss_free;
    assign rr_next  = (gnt_slot == PW'(size - 1)) ? '0 : gnt_slot + 1'b1;

    // A slot may be picked only once per trip through the pipeline
    always_comb begin
        for (int i = 0; i < size; i++) begin
            elig[i] = ready[i] & data[i].valid & ~inflight[i];
        end
    end

    // Round-robin search starting at rr_ptr, wrapping past size-1 to 0
    always_comb begin
        gnt_vld  = 1'b0;
        gnt_slot = '0;
        rr_idx   = '0;
        for (int k = 0; k < size; k++) begin
            rr_idx = PW'((int'(rr_ptr) + k) % size);
            if (!gnt_vld && elig[rr_idx]) begin
                gnt_vld  = 1'b1;
                gnt_slot = rr_idx;
            end
        end
    end

    // Execute from the issue register; compare results are zero-extended flags
    always_comb begin
        alu_res = '0;
        case (iss_q.alu_op)
            ALU_ADD: alu_res = iss_q.r1 + iss_q.r2;
            ALU_SUB: alu_res = iss_q.r1 - iss_q.r2;
            ALU_SLL: alu_res = iss_q.r1 << iss_q.r2[4:0];
            ALU_SRL: alu_res = iss_q.r1 >> iss_q.r2[4:0];
            ALU_SRA: alu_res = $unsigned($signed(iss_q.r1) >>> iss_q.r2[4:0]);
            ALU_XOR: alu_res = iss_q.r1 ^ iss_q.r2;
            ALU_OR:  alu_res = iss_q.r1 | iss_q.r2;
            ALU_AND: alu_res = iss_q.r1 & iss_q.r2;
            default: alu_res = '0;
        endcase
        cmp_res = 1'b0;
        case (iss_q.cmp_op)
            CMP_BEQ:  cmp_res = (iss_q.r1 == iss_q.r2);
            CMP_BNE:  cmp_res = (iss_q.r1 != iss_q.r2);
            CMP_BLT:  cmp_res = ($signed(iss_q.r1) <  $signed(iss_q.r2));
            CMP_BGE:  cmp_res = ($signed(iss_q.r1) >= $signed(iss_q.r2));
            CMP_BLTU: cmp_res = (iss_q.r1 <  iss_q.r2);
            CMP_BGEU: cmp_res = (iss_q.r1 >= iss_q.r2);
            default:  cmp_res = 1'b0;
        endcase
        exe_res = iss_q.acu ? {31'b0, cmp_res} : alu_res;
    end

    // Control state: valid bits, in-flight mask and arbiter pointer; flush behaves like reset
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            iss_vld  <= 1'b0;
            res_vld  <= 1'b0;
            inflight <= '0;
            rr_ptr   <= '0;
        end else begin
            if (iss_adv) begin
                res_vld <= 1'b1;
            end else if (consume) begin
                res_vld <= 1'b0;
            end

            if (grant) begin
                iss_vld <= 1'b1;
                rr_ptr  <= rr_next;
            end else if (iss_adv) begin
                iss_vld <= 1'b0;
            end

            // Granted slot is never the consumed one, so set and clear never collide
            for (int i = 0; i < size; i++) begin
                if (grant && gnt_slot == PW'(i)) begin
                    inflight[i] <= 1'b1;
                end else if (consume && res_slot == PW'(i)) begin
                    inflight[i] <= 1'b0;
                end
            end
        end
    end

    // Payload registers; qualified by the valid bits so they need no reset
    always_ff @(posedge clk) begin
        if (grant) begin
            iss_q <= '{slot:   gnt_slot,
                       tag:    data[gnt_slot].tag,
                       r1:     data[gnt_slot].r1,
                       r2:     data[gnt_slot].r2,
                       alu_op: data[gnt_slot].alu_opcode,
                       cmp_op: data[gnt_slot].cmp_opcode,
                       acu:    acu_operation[gnt_slot]};
        end
        if (iss_adv) begin
            res_slot <= iss_q.slot;
            res_tag  <= iss_q.tag;
            res_dat  <= exe_res;
        end
    end

    // Done pulse to the owning slot only when the ROB takes the result
    always_comb begin
        for (int i = 0; i < size; i++) begin
            broadcast_bus[i] = '0;
        end
        if (consume) begin
            broadcast_bus[res_slot] = '{rdy: 1'b1, tag: res_tag, data: res_dat};
        end
    end

    // Gather rdy bits for the one-hot check
    always_comb begin
        for (int i = 0; i < size; i++) begin
            bb_rdy[i] = broadcast_bus[i].rdy;
        end
    end

    assign cdb_valid = consume;
    assign cdb_tag   = res_vld ? res_tag : '0;
    assign cdb_data  = res_vld ? res_dat : '0;
    assign busy      = iss_vld | res_vld;

    rdy_onehot_a: assert property (@(posedge clk) disable iff (rst) $onehot0(bb_rdy));
    no_double_grant_a: assert property (@(posedge clk) disable iff (rst || flush)
                                        grant |-> !inflight[gnt_slot]);

endmodule
